// File: rtl/rv_pkg.sv
// Shared RV32 pipeline definitions: writeback-source codes, load funct3 codes
// and the MEM/WB pipeline register layout.
package rv_pkg;

    localparam logic [1:0] WB_SEL_MEM  = 2'b00;
    localparam logic [1:0] WB_SEL_ALU  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_RSVD = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb_sel;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] pc_plus4;
        logic [31:0] load_word;
    } mem_wb_t;

    // Halfwords need an even offset, words a zero offset; bytes never misalign.
    function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_LH, F3_LHU: mis = off[0];
            F3_LW:         mis = (off != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM-to-WB bundle plus the register-file write port, forwarding bus and
// retire counter leaving the writeback stage.
interface wb_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             mem_valid;
    logic [1:0]       mem_wb_sel;
    logic             mem_reg_wen;
    logic [4:0]       mem_rd;
    logic [2:0]       mem_funct3;
    logic [XLEN-1:0]  mem_alu_result;
    logic [XLEN-1:0]  mem_pc_plus4;
    logic [XLEN-1:0]  mem_load_word;
    logic             stall;
    logic             flush;

    logic             rf_we;
    logic [4:0]       rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             fwd_valid;
    logic [4:0]       fwd_rd;
    logic [XLEN-1:0]  fwd_data;
    logic             load_misalign;
    logic [CNT_W-1:0] instret;

    modport master (
        output mem_valid, mem_wb_sel, mem_reg_wen, mem_rd, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_load_word, stall, flush,
        input  rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               load_misalign, instret
    );

    modport slave (
        input  mem_valid, mem_wb_sel, mem_reg_wen, mem_rd, mem_funct3,
               mem_alu_result, mem_pc_plus4, mem_load_word, stall, flush,
        output rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_rd, fwd_data,
               load_misalign, instret
    );
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of an aligned memory word and
// sign- or zero-extends it according to the load funct3.
module load_align
    import rv_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (off_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        // Odd halfword offsets are flagged as misaligned upstream; off[1] alone picks the half.
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   data_o = word_i;
            F3_LBU:  data_o = {24'd0, byte_sel};
            F3_LHU:  data_o = {16'd0, half_sel};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32 writeback stage: MEM/WB register, load alignment, source select,
// register-file write/forwarding drive and retired-instruction counter.
module wb_stage
    import rv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic      clk,
    input  logic      rst_n,
    wb_stage_if.slave bus
);
    mem_wb_t          wb_q;
    mem_wb_t          wb_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic             retire;
    logic [1:0]       off;
    logic [XLEN-1:0]  load_data;
    logic [XLEN-1:0]  wdata;
    logic             misalign;
    logic             we;

    // Flush wins over stall; only valid needs clearing, the rest is don't-care.
    always_comb begin
        wb_d = wb_q;
        if (bus.flush) begin
            wb_d.valid = 1'b0;
        end else if (!bus.stall) begin
            wb_d.valid      = bus.mem_valid;
            wb_d.wb_sel     = bus.mem_wb_sel;
            wb_d.reg_wen    = bus.mem_reg_wen;
            wb_d.rd         = bus.mem_rd;
            wb_d.funct3     = bus.mem_funct3;
            wb_d.alu_result = bus.mem_alu_result;
            wb_d.pc_plus4   = bus.mem_pc_plus4;
            wb_d.load_word  = bus.mem_load_word;
        end
    end

    // Retirement happens when the instruction leaves WB, so a stalled one counts once.
    assign retire    = wb_q.valid & ~bus.stall & ~bus.flush;
    assign instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q      <= '0;
            instret_q <= '0;
        end else begin
            wb_q      <= wb_d;
            instret_q <= instret_d;
        end
    end

    assign off = wb_q.alu_result[1:0];

    load_align u_load_align (
        .word_i   (wb_q.load_word),
        .off_i    (off),
        .funct3_i (wb_q.funct3),
        .data_o   (load_data)
    );

    assign misalign = wb_q.valid & (wb_q.wb_sel == WB_SEL_MEM) & wb_q.reg_wen
                    & load_misaligned(wb_q.funct3, off);

    always_comb begin
        case (wb_q.wb_sel)
            WB_SEL_MEM: wdata = load_data;
            WB_SEL_ALU: wdata = wb_q.alu_result;
            WB_SEL_PC4: wdata = wb_q.pc_plus4;
            default:    wdata = '0;
        endcase
    end

    assign we = wb_q.valid & wb_q.reg_wen & (wb_q.rd != 5'd0)
              & (wb_q.wb_sel != WB_SEL_RSVD) & ~misalign;

    assign bus.rf_we         = we;
    assign bus.rf_waddr      = wb_q.rd;
    assign bus.rf_wdata      = wdata;
    assign bus.fwd_valid     = we;
    assign bus.fwd_rd        = wb_q.rd;
    assign bus.fwd_data      = wdata;
    assign bus.load_misalign = misalign;
    assign bus.instret       = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed scoreboard bench for wb_stage; a 4-bit-counter copy shares the
// stimulus so counter wrap is observed alongside the 64-bit instance.
module tb_wb_stage;
    import rv_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_stage_if #(.XLEN(32), .CNT_W(64)) bus  ();
    wb_stage_if #(.XLEN(32), .CNT_W(4))  bus4 ();

    wb_stage #(.XLEN(32), .CNT_W(64)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    wb_stage #(.XLEN(32), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

    assign bus4.mem_valid      = bus.mem_valid;
    assign bus4.mem_wb_sel     = bus.mem_wb_sel;
    assign bus4.mem_reg_wen    = bus.mem_reg_wen;
    assign bus4.mem_rd         = bus.mem_rd;
    assign bus4.mem_funct3     = bus.mem_funct3;
    assign bus4.mem_alu_result = bus.mem_alu_result;
    assign bus4.mem_pc_plus4   = bus.mem_pc_plus4;
    assign bus4.mem_load_word  = bus.mem_load_word;
    assign bus4.stall          = bus.stall;
    assign bus4.flush          = bus.flush;

    typedef struct {
        int          id;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          txn_id = 0;
    event        chk_ev;
    logic        exp_valid_q = 1'b0;
    logic [63:0] exp_cnt = 64'd0;

    localparam logic [31:0] WORD = 32'h80FF7F01;

    task automatic chk(input string name, input int id, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s txn %0d got %h expected %h", name, id, got, exp);
        end
    endtask

    // Monitor: compares whatever the DUTs present against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or chk_ev);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("rf_we",     e.id, 64'(bus.rf_we),         64'(e.we));
                chk("fwd_valid", e.id, 64'(bus.fwd_valid),     64'(e.we));
                chk("misalign",  e.id, 64'(bus.load_misalign), 64'(e.mis));
                chk("instret",   e.id, bus.instret,            e.cnt);
                chk("instret4",  e.id, 64'(bus4.instret),      64'(e.cnt[3:0]));
                if (e.we) begin
                    chk("rf_waddr", e.id, 64'(bus.rf_waddr), 64'(e.rd));
                    chk("rf_wdata", e.id, 64'(bus.rf_wdata), 64'(e.data));
                    chk("fwd_rd",   e.id, 64'(bus.fwd_rd),   64'(e.rd));
                    chk("fwd_data", e.id, 64'(bus.fwd_data), 64'(e.data));
                end
            end
        end
    end

    task automatic push_exp(input logic we, input logic [4:0] rd, input logic [31:0] data, input logic mis);
        exp_t e;
        e.id   = txn_id;
        e.we   = we;
        e.rd   = rd;
        e.data = data;
        e.mis  = mis;
        e.cnt  = exp_cnt;
        sb_q.push_back(e);
    endtask

    // Drive one cycle of MEM-side inputs, clock it in, queue the expected WB outputs.
    task automatic issue(input logic v, input logic [1:0] sel, input logic wen, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] word, input logic st, input logic fl,
                         input logic e_we, input logic [4:0] e_rd, input logic [31:0] e_data,
                         input logic e_mis);
        bus.mem_valid      = v;
        bus.mem_wb_sel     = sel;
        bus.mem_reg_wen    = wen;
        bus.mem_rd         = rd;
        bus.mem_funct3     = f3;
        bus.mem_alu_result = alu;
        bus.mem_pc_plus4   = pc4;
        bus.mem_load_word  = word;
        bus.stall          = st;
        bus.flush          = fl;
        @(posedge clk);
        if (exp_valid_q && !st && !fl) exp_cnt = exp_cnt + 64'd1;
        exp_valid_q = fl ? 1'b0 : (st ? exp_valid_q : v);
        #1;
        txn_id++;
        push_exp(e_we, e_rd, e_data, e_mis);
        $display("txn %0d v=%0b sel=%0d wen=%0b rd=%0d f3=%0d alu=%h st=%0b fl=%0b exp_we=%0b exp_data=%h",
                 txn_id, v, sel, wen, rd, f3, alu, st, fl, e_we, e_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        bus.mem_valid = 0; bus.mem_wb_sel = 0; bus.mem_reg_wen = 0; bus.mem_rd = 0;
        bus.mem_funct3 = 0; bus.mem_alu_result = 0; bus.mem_pc_plus4 = 0;
        bus.mem_load_word = 0; bus.stall = 0; bus.flush = 0;

        // Outputs while reset is held
        #2;
        push_exp(1'b0, 5'd0, 32'd0, 1'b0);
        chk("rst_wdata", 0, 64'(bus.rf_wdata), 64'd0);
        chk("rst_waddr", 0, 64'(bus.rf_waddr), 64'd0);
        ->chk_ev;
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        //    v  sel    wen rd     f3      alu           pc4           word   st fl  e_we e_rd   e_data         e_mis
        issue(1, 2'b00, 1, 5'd5,  F3_LB,  32'h0000_1003, 32'h0,       WORD,   0, 0,  1, 5'd5,  32'hFFFFFF80, 0);
        issue(1, 2'b00, 1, 5'd6,  F3_LHU, 32'h0000_1002, 32'h0,       WORD,   0, 0,  1, 5'd6,  32'h000080FF, 0);
        issue(1, 2'b00, 1, 5'd6,  F3_LH,  32'h0000_1001, 32'h0,       WORD,   0, 0,  0, 5'd6,  32'h0,        1);
        issue(1, 2'b10, 1, 5'd1,  3'd0,   32'h0000_0123, 32'h1004,    WORD,   0, 0,  1, 5'd1,  32'h00001004, 0);
        issue(1, 2'b01, 1, 5'd0,  3'd0,   32'h0000_0055, 32'h0,       WORD,   0, 0,  0, 5'd0,  32'h55,       0);
        issue(1, 2'b00, 1, 5'd8,  F3_LW,  32'h0000_2000, 32'h0,       WORD,   0, 0,  1, 5'd8,  32'h80FF7F01, 0);
        issue(1, 2'b00, 1, 5'd9,  F3_LBU, 32'h0000_2002, 32'h0,       WORD,   0, 0,  1, 5'd9,  32'h000000FF, 0);
        issue(1, 2'b00, 1, 5'd10, F3_LB,  32'h0000_2001, 32'h0,       WORD,   0, 0,  1, 5'd10, 32'h0000007F, 0);
        issue(1, 2'b00, 1, 5'd11, F3_LH,  32'h0000_2000, 32'h0,       WORD,   0, 0,  1, 5'd11, 32'h00007F01, 0);
        issue(1, 2'b00, 1, 5'd12, F3_LH,  32'h0000_2002, 32'h0,       WORD,   0, 0,  1, 5'd12, 32'hFFFF80FF, 0);
        issue(1, 2'b00, 1, 5'd13, 3'b011, 32'h0000_2000, 32'h0,       WORD,   0, 0,  1, 5'd13, 32'h00000000, 0);
        issue(1, 2'b00, 1, 5'd14, F3_LW,  32'h0000_2002, 32'h0,       WORD,   0, 0,  0, 5'd14, 32'h0,        1);
        issue(1, 2'b00, 1, 5'd15, F3_LHU, 32'h0000_2003, 32'h0,       WORD,   0, 0,  0, 5'd15, 32'h0,        1);
        issue(1, 2'b00, 0, 5'd3,  F3_LW,  32'h0000_2001, 32'h0,       WORD,   0, 0,  0, 5'd3,  32'h0,        0);
        issue(1, 2'b11, 1, 5'd16, 3'd0,   32'h0000_0077, 32'h88,      WORD,   0, 0,  0, 5'd16, 32'h0,        0);
        // Stall holds the ALU op for three cycles despite changing MEM inputs
        issue(1, 2'b01, 1, 5'd7,  3'd0,   32'h0000_DEAD, 32'h0,       WORD,   0, 0,  1, 5'd7,  32'h0000DEAD, 0);
        issue(1, 2'b01, 1, 5'd9,  3'd0,   32'h0000_BEEF, 32'h0,       WORD,   1, 0,  1, 5'd7,  32'h0000DEAD, 0);
        issue(1, 2'b10, 1, 5'd2,  3'd0,   32'h0000_BEEF, 32'h2222,    WORD,   1, 0,  1, 5'd7,  32'h0000DEAD, 0);
        issue(1, 2'b01, 1, 5'd9,  3'd0,   32'h0000_BEEF, 32'h0,       WORD,   1, 0,  1, 5'd7,  32'h0000DEAD, 0);
        issue(0, 2'b01, 1, 5'd9,  3'd0,   32'h0000_BEEF, 32'h0,       WORD,   0, 0,  0, 5'd9,  32'h0,        0);
        issue(1, 2'b01, 1, 5'd4,  3'd0,   32'h0000_0044, 32'h0,       WORD,   0, 0,  1, 5'd4,  32'h00000044, 0);
        issue(1, 2'b01, 1, 5'd4,  3'd0,   32'h0000_0045, 32'h0,       WORD,   1, 1,  0, 5'd4,  32'h0,        0);
        issue(0, 2'b01, 0, 5'd0,  3'd0,   32'h0,         32'h0,       WORD,   0, 0,  0, 5'd0,  32'h0,        0);
        // Reset pulse between edges with a valid op in WB
        issue(1, 2'b01, 1, 5'd3,  3'd0,   32'h0000_1234, 32'h0,       WORD,   0, 0,  1, 5'd3,  32'h00001234, 0);
        @(negedge clk); #1;
        bus.mem_valid = 1'b0;
        rst_n = 1'b0;
        exp_cnt = 64'd0;
        exp_valid_q = 1'b0;
        #1;
        push_exp(1'b0, 5'd0, 32'h0, 1'b0);
        ->chk_ev;
        #1 rst_n = 1'b1;
        issue(0, 2'b01, 1, 5'd3,  3'd0,   32'h0000_1234, 32'h0,       WORD,   0, 0,  0, 5'd3,  32'h0,        0);
        // Seventeen retirements: the 4-bit copy wraps to 1
        for (int i = 0; i < 17; i++) begin
            issue(1, 2'b01, 1, 5'(i + 1), 3'd0, 32'(i * 3 + 1), 32'h0, WORD, 0, 0,
                  1, 5'(i + 1), 32'(i * 3 + 1), 0);
        end
        issue(0, 2'b01, 0, 5'd0,  3'd0,   32'h0,         32'h0,       WORD,   0, 0,  0, 5'd0,  32'h0,        0);
        chk("wrap_model", txn_id, exp_cnt, 64'd17);

        repeat (3) @(negedge clk);
        #1;
        chk("sb_drained", txn_id, 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32 pipeline, directly downstream of the writeback-select control. Holds the MEM/WB pipeline register, aligns and extends load data, and selects the writeback source (load data, ALU result or PC+4) using the registered `wb_sel`/`regWEn` pair. Drives the register-file write port and the WB-to-EX forwarding bus. Also counts retired instructions.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `CNT_W`, 64: width of the retired-instruction counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  the MEM stage holds a real instruction.
- `mem_wb_sel`  in  2  writeback source: 00 load, 01 ALU, 10 PC+4, 11 reserved.
- `mem_reg_wen`  in  1  instruction writes rd.
- `mem_rd`  in  5  destination register index.
- `mem_funct3`  in  3  load width and sign, used when `wb_sel`=00.
- `mem_alu_result`  in  32  ALU result; bits [1:0] are the load byte offset.
- `mem_pc_plus4`  in  32  link value for JAL/JALR.
- `mem_load_word`  in  32  raw aligned word from data memory.
- `stall`  in  1  hold the WB register contents.
- `flush`  in  1  invalidate the WB register contents.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  register-file write index.
- `rf_wdata`  out  32  register-file write data.
- `fwd_valid`  out  1  forwarding bus valid; equals `rf_we`.
- `fwd_rd`  out  5  forwarding destination index.
- `fwd_data`  out  32  forwarding data.
- `load_misalign`  out  1  registered instruction is a misaligned load.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- **Capture.** On each edge, if `flush`=1 then `wb_valid` is cleared and all other fields are don't-care.
  - Otherwise, if `stall`=0, every `mem_*` field is captured.
  - Otherwise (stall only), the register holds.
  - `flush` beats `stall`.
- **Load align.** `off` = `wb_alu_result[1:0]`. Select the byte or halfword at `off` from the word, then extend.
  - funct3 000 LB: sign-extend byte.
  - 001 LH: sign-extend halfword.
  - 010 LW: whole word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend halfword.
  - 011, 110, 111: result is 0.
- **Misalign.** `load_misalign` = `wb_valid` & `wb_sel`==00 & `reg_wen` & ((LH/LHU & off[0]) | (LW & off≠0)).
- **Source select.** `wb_sel` 00 gives aligned load data, 01 gives `alu_result`, 10 gives `pc_plus4`, 11 gives 0.
- **Write enable.** `rf_we` = `wb_valid` & `reg_wen` & `rd`≠0 & `wb_sel`≠11 & !`load_misalign`.
- **Retire.** `instret` increments by 1 on every edge where `wb_valid`=1, `stall`=0 and `flush`=0. This includes stores, branches and suppressed writes. The counter wraps modulo 2^CNT_W.

## Timing
- **Reset.** `rst_n` low clears `wb_valid`, all WB fields and `instret` immediately. All outputs are 0 while reset is held. Reset mid-stream discards the in-flight instruction, which is neither written nor counted.
- **Latency.** One cycle from MEM capture to `rf_we`. The `rf_*`, `fwd_*` and `load_misalign` outputs are purely combinational from the WB register: no added latency and no dependency on `mem_*`.
- **Stall.** Outputs stay constant across stall cycles. The register file sees the same write repeated, which is idempotent. `instret` counts the instruction once, on the releasing edge.
- **Flush and stall together.** `flush`=1 with `stall`=1: the next cycle shows `rf_we`=0.
- **Write/read same cycle.** The register file must be write-first, or the decode stage must use `fwd_*`, when a read in the same cycle targets `rf_waddr`.

## Structure
- **Shared package `rv_pkg`.**
  - WB_SEL_MEM/ALU/PC4/RSVD constants (2-bit).
  - Load funct3 constants F3_LB/LH/LW/LBU/LHU.
  - A packed `mem_wb_t` struct of the captured fields.
- **Sub-module `load_align`.** Combinational: word, offset and funct3 in; 32-bit result out.
- **Top level.** The top holds the pipeline register, the source mux, the write-enable logic and the counter.

## Test plan
- **LB sign extension.** word 0x80FF7F01, funct3 000, off 3, rd 5 -> next cycle `rf_we`=1, `waddr` 5, `wdata` 0xFFFFFF80.
- **Load variants.**
  - LHU, same word, off 2, gives 0x000080FF.
  - LH, off 1, gives `load_misalign`=1 and `rf_we`=0.
- **Source select.**
  - `wb_sel` 10 with `pc_plus4` 0x1004, rd 1 -> `wdata` 0x1004.
  - rd 0 -> `rf_we`=0 and `instret` still +1.
- **Stall then flush.** Valid ALU op 0xDEAD, rd 7. Stall 3 cycles: outputs constant and `instret` +0. Release: +1. Assert flush together with stall: next cycle `rf_we`=0.
- **Reset mid-stream.** Pulse `rst_n` low between edges with a valid op held -> `rf_we` drops asynchronously and `instret`=0.
- **Counter wrap.** With CNT_W=4, retire 17 instructions -> `instret`=1.
